// File: rtl/sio_sram_slave.sv
// Byte-wide SIO slave on a synchronous single-port RAM, with a byte-stream preload port filling it from address 0 after reset.
// Ready 1+WAIT_CYCLES cycles after accept (1 on range error); the SIO master stalls until preload is done.
module sio_sram_slave #(
  parameter int MEM_BYTES   = 1048576,
  parameter int ADDR_W      = 64,
  parameter int WAIT_CYCLES = 0,
  parameter bit PRELOAD_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sio_taskValid,
  input  logic              sio_rwCtrl,
  input  logic [ADDR_W-1:0] sio_address,
  input  logic [7:0]        sio_writeBus,
  output logic              sio_taskReady,
  output logic              sio_taskError,
  output logic [7:0]        sio_readBus,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              boot_done,
  output logic              load_overflow
);
  localparam int IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(MEM_BYTES - 1);
  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);
  localparam logic [3:0]        WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {LOAD, IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] loadPtr;
  logic [3:0]       waitCnt;
  logic             errQ;
  logic             writeQ;
  logic [7:0]       mem [MEM_BYTES];
  logic [7:0]       ramQ;
  logic             ramWe;
  logic [IDX_W-1:0] ramIdx;
  logic [7:0]       ramWData;
  logic             inRange;

  assign inRange = sio_address < MEM_LIMIT;

  // One shared RAM port: preload owns it in LOAD, the SIO address everywhere else.
  always_comb begin
    ramIdx   = sio_address[IDX_W-1:0];
    ramWData = sio_writeBus;
    ramWe    = 1'b0;
    if (state == LOAD) begin
      ramIdx   = loadPtr;
      ramWData = load_data;
      ramWe    = load_ready && load_valid;
    end else if (state == RESP) begin
      ramWe = sio_taskValid && writeQ && !errQ;
    end
  end

  always_ff @(posedge clk) begin
    if (ramWe) begin
      mem[ramIdx] <= ramWData;
    end else if (state == IDLE && sio_taskValid) begin
      ramQ <= mem[ramIdx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= PRELOAD_EN ? LOAD : IDLE;
      loadPtr       <= '0;
      waitCnt       <= '0;
      errQ          <= 1'b0;
      writeQ        <= 1'b0;
      load_ready    <= 1'b0;
      boot_done     <= !PRELOAD_EN;
      load_overflow <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          // load_ready is held low through reset, so it rises on the first clock in LOAD.
          if (!load_ready) begin
            load_ready <= 1'b1;
          end else if (load_valid) begin
            loadPtr <= loadPtr + IDX_W'(1);
            if (load_last || loadPtr == LAST_IDX) begin
              state         <= IDLE;
              load_ready    <= 1'b0;
              boot_done     <= 1'b1;
              load_overflow <= !load_last;
            end
          end
        end
        IDLE: begin
          if (sio_taskValid) begin
            writeQ  <= sio_rwCtrl;
            errQ    <= !inRange;
            waitCnt <= WAIT_INIT;
            if (!inRange || WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!sio_taskValid) begin
            state <= IDLE;
          end else if (waitCnt == 4'd0) begin
            state <= RESP;
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Response is qualified by taskValid so a master that drops its request in RESP sees no pulse.
  assign sio_taskReady = (state == RESP) && sio_taskValid;
  assign sio_taskError = sio_taskReady && errQ;
  assign sio_readBus   = (sio_taskReady && !errQ && !writeQ) ? ramQ : 8'h00;

endmodule
